multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore-style control FSM that sequences a multi-cycle version of the team's MIPS-subset datapath (Ifetch/PC, IR, RegFiles, Ext, ALU, DataRAM), replacing the single-cycle combinational ControlUnit.
- Decodes OP/func from the held instruction register and steps IF → ID → EX → MEM → WB.
- Waits on a data-memory ready handshake and aborts a stalled access after a bounded number of cycles.

Parameters:
- WAIT_LIMIT, 15: maximum wait cycles in a MEM state before timeout; 0 disables the timeout.
- WAIT_W, 4: width of the wait counter; must satisfy 2^WAIT_W > WAIT_LIMIT.

Ports:
- Clk  in  1  single clock; all state updates on the rising edge.
- Clrn  in  1  reset, synchronous, active-low.
- OP  in  6  IR[31:26], held by the datapath from ID onward.
- func  in  6  IR[5:0].
- Z  in  1  ALU zero flag.
- Overflow  in  1  ALU signed overflow.
- MemReady  in  1  DataRAM access complete this cycle.
- PCWr  out  1  PC write enable.
- IRWr  out  1  IR write enable.
- PCSrc  out  2  next-PC select: 00 = ALU (PC+4), 01 = ALUOut (branch target), 10 = jump target.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = busA.
- ALUSrcB  out  2  ALU B select: 00 = busB, 01 = constant 4, 10 = imm32, 11 = imm32<<2.
- ALUctr  out  3  ALU operation.
- ExtOp  out  1  1 = sign-extend, 0 = zero-extend.
- RegDst  out  1  1 = rd, 0 = rt.
- MemToReg  out  1  1 = memory data, 0 = ALUOut.
- RegWr  out  1  register-file write enable.
- MemRd  out  1  data-memory read strobe.
- MemWr  out  1  data-memory write strobe.
- Illegal  out  1  one-cycle pulse on an undecodable instruction.
- Fault  out  1  one-cycle pulse on a memory timeout.
- State  out  4  current state, for debug.

Behaviour:
- Reset: when Clrn=0 at a rising edge, state←IF, ovf_q←0, wait_cnt←0.
- While Clrn=0, PCWr, IRWr, RegWr, MemRd, MemWr, Illegal and Fault are forced to 0. All other outputs show their IF values.
- Reset mid-operation abandons the instruction with no further writes.
- Outputs are decoded combinationally from the state register and the latched opcode. Any control not listed for a state is 0.
- IF: IRWr=1, PCWr=1, PCSrc=00, ALUSrcA=0, ALUSrcB=01, ALUctr=ADDU. Next state is ID.
- ID: ALUSrcA=0, ALUSrcB=11, ExtOp=1, ALUctr=ADDU; the datapath latches the branch target into ALUOut. Next state by opcode:
  - R-type → EX_R.
  - addi, addiu, ori → EX_I.
  - lw, sw → EX_AD.
  - beq → EX_BR.
  - j: PCWr=1, PCSrc=10 in ID, then IF.
  - anything else: Illegal=1, then IF (executes as a nop).
- EX_R: ALUSrcA=1, ALUSrcB=00, ALUctr from func. Unknown func: Illegal=1 and go to IF. Otherwise ovf_q←Overflow, then WB_R.
- EX_I: ALUSrcA=1, ALUSrcB=10. ExtOp=0 for ori, 1 otherwise. ovf_q←Overflow, then WB_I.
- EX_AD: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUctr=ADDU. Next is MEM_LD for lw, MEM_ST for sw.
- EX_BR: ALUSrcA=1, ALUSrcB=00, ALUctr=SUB, PCSrc=01, PCWr=Z. Then IF.
- MEM_LD / MEM_ST: MemRd (resp. MemWr) is held high every cycle spent in the state.
  - MemReady=1: advance (MEM_LD → WB_LD, MEM_ST → IF); wait_cnt←0.
  - MemReady=0 and wait_cnt==WAIT_LIMIT (with WAIT_LIMIT≠0): Fault=1 and go to IF with no register write; wait_cnt←0.
  - Otherwise stay and increment wait_cnt.
  - MemReady arriving in the same cycle as the limit wins (the access completes).
- WB_R: RegDst=1, MemToReg=0. WB_I: RegDst=0, MemToReg=0. In both, RegWr=~ovf_q for add/sub/addi and 1 for all other ops. Then IF.
- WB_LD: RegDst=0, MemToReg=1, RegWr=1. Then IF.
- Cycles per instruction with no memory waits: j=2, beq=3, R/I/sw=4, lw=5. Each memory wait cycle adds 1.
- ALUctr encoding: ADDU=000, ADD=001, SUB=010, AND=011, OR=100, SLT=101, SLTU=110.
- R-type func decode: 100000 add, 100001 addu, 100010 sub, 100100 and, 100101 or, 101010 slt, 101011 sltu.
- Opcodes: 000000 R-type, 001000 addi, 001001 addiu, 001101 ori, 100011 lw, 101011 sw, 000100 beq, 000010 j.
- State encoding: IF=0, ID=1, EX_R=2, EX_I=3, EX_AD=4, EX_BR=5, MEM_LD=6, MEM_ST=7, WB_R=8, WB_I=9, WB_LD=10. Codes 11–15 are unreachable and recover to IF on the next edge.

Decomposition:
- cpu_defs.vh (shared include) holds the opcode, func, ALUctr, PCSrc, ALUSrcB and state-code constants; the ALU and datapath use the same file.
- One natural sub-module: mc_decode, combinational opcode/func → instruction-class and ALUctr lookup. It is used by both the next-state logic and the output decode.

Test Plan:
- Clrn=0 for 2 cycles mid-lw, then release → State=0 and no RegWr/MemWr while reset; IF strobes (PCWr, IRWr) resume on the first cycle after release.
- addu (OP=0, func=100001) → states 0,1,2,8; RegWr=1 and RegDst=1 only in state 8.
- add with Overflow=1 in EX_R → WB_R has RegWr=0; a following addu with Overflow=1 → RegWr=1.
- lw with MemReady low for 3 cycles → MemRd high for 4 cycles in state 6, then WB_LD with MemToReg=1, RegWr=1; total 8 cycles.
- sw with MemReady held 0 → Fault pulse after 16 cycles in state 7, next state IF, no RegWr.
- beq with Z=1, then with Z=0 → PCWr=1, PCSrc=01 in state 5 for the first and PCWr=0 for the second. j → PCWr=1, PCSrc=10 in state 1. OP=111111 → Illegal pulse in ID, then back to IF.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants and types for the multi-cycle MIPS-subset controller.
package multicycle_ctrl_pkg;

  // Controller states; codes 11-15 are unused.
  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EX_R   = 4'd2,
    S_EX_I   = 4'd3,
    S_EX_AD  = 4'd4,
    S_EX_BR  = 4'd5,
    S_MEM_LD = 4'd6,
    S_MEM_ST = 4'd7,
    S_WB_R   = 4'd8,
    S_WB_I   = 4'd9,
    S_WB_LD  = 4'd10
  } state_t;

  // Instruction classes produced by the opcode decoder.
  typedef enum logic [2:0] {
    CL_R,
    CL_I,
    CL_LS,
    CL_BR,
    CL_J,
    CL_ILL
  } iclass_t;

  // Opcodes (IR[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (IR[5:0]).
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  // ALU operation codes.
  localparam logic [2:0] ALU_ADDU = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  // Next-PC select.
  localparam logic [1:0] PCSRC_PC4  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  // ALU B-operand select.
  localparam logic [1:0] ASB_BUSB  = 2'b00;
  localparam logic [1:0] ASB_FOUR  = 2'b01;
  localparam logic [1:0] ASB_IMM   = 2'b10;
  localparam logic [1:0] ASB_IMMSH = 2'b11;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/func decode: instruction class and ALU operation.
module mc_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_func,
  output iclass_t    o_class,
  output logic       o_is_lw,
  output logic       o_zext,
  output logic       o_func_ok,
  output logic       o_ovf_trap,
  output logic [2:0] o_alu_r,
  output logic [2:0] o_alu_i
);

  // Opcode class, I-type ALU op, R-type func lookup and overflow-trapping ops.
  always_comb begin
    o_class  = CL_ILL;
    o_is_lw  = 1'b0;
    o_zext   = 1'b0;
    o_alu_i  = ALU_ADDU;
    case (i_op)
      OP_RTYPE: o_class = CL_R;
      OP_ADDI: begin
        o_class = CL_I;
        o_alu_i = ALU_ADD;
      end
      OP_ADDIU: o_class = CL_I;
      OP_ORI: begin
        o_class = CL_I;
        o_alu_i = ALU_OR;
        o_zext  = 1'b1;
      end
      OP_LW: begin
        o_class = CL_LS;
        o_is_lw = 1'b1;
      end
      OP_SW:  o_class = CL_LS;
      OP_BEQ: o_class = CL_BR;
      OP_J:   o_class = CL_J;
      default: o_class = CL_ILL;
    endcase

    o_func_ok = 1'b1;
    o_alu_r   = ALU_ADDU;
    case (i_func)
      FN_ADD:  o_alu_r = ALU_ADD;
      FN_ADDU: o_alu_r = ALU_ADDU;
      FN_SUB:  o_alu_r = ALU_SUB;
      FN_AND:  o_alu_r = ALU_AND;
      FN_OR:   o_alu_r = ALU_OR;
      FN_SLT:  o_alu_r = ALU_SLT;
      FN_SLTU: o_alu_r = ALU_SLTU;
      default: o_func_ok = 1'b0;
    endcase

    o_ovf_trap = (i_op == OP_ADDI) ||
                 ((i_op == OP_RTYPE) && ((i_func == FN_ADD) || (i_func == FN_SUB)));
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multi-cycle MIPS-subset datapath.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15,  // 0 disables the memory timeout
  parameter int unsigned WAIT_W     = 4    // 2**WAIT_W must exceed WAIT_LIMIT
) (
  input  logic       Clk,
  input  logic       Clrn,
  input  logic [5:0] OP,
  input  logic [5:0] func,
  input  logic       Z,
  input  logic       Overflow,
  input  logic       MemReady,
  output logic       PCWr,
  output logic       IRWr,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUctr,
  output logic       ExtOp,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       RegWr,
  output logic       MemRd,
  output logic       MemWr,
  output logic       Illegal,
  output logic       Fault,
  output logic [3:0] State
);

  state_t            r_state;
  logic              r_ovf;
  logic [WAIT_W-1:0] r_wait;

  state_t            w_cur;
  state_t            w_next;
  logic              w_ovf_ld;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              w_limit_hit;

  iclass_t           w_class;
  logic              w_is_lw;
  logic              w_zext;
  logic              w_func_ok;
  logic              w_ovf_trap;
  logic [2:0]        w_alu_r;
  logic [2:0]        w_alu_i;

  mc_decode u_decode (
    .i_op       (OP),
    .i_func     (func),
    .o_class    (w_class),
    .o_is_lw    (w_is_lw),
    .o_zext     (w_zext),
    .o_func_ok  (w_func_ok),
    .o_ovf_trap (w_ovf_trap),
    .o_alu_r    (w_alu_r),
    .o_alu_i    (w_alu_i)
  );

  // While reset is held the outputs already show the IF decode, before the edge lands.
  assign w_cur       = Clrn ? r_state : S_IF;
  assign State       = w_cur;
  assign w_limit_hit = (WAIT_LIMIT != 0) && (r_wait == WAIT_W'(WAIT_LIMIT));

  // State register, latched overflow flag and memory wait counter.
  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      r_state <= S_IF;
      r_ovf   <= 1'b0;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_nxt;
      if (w_ovf_ld) r_ovf <= Overflow;
    end
  end

  // Next-state and Moore output decode; write strobes are masked during reset.
  always_comb begin
    w_next     = S_IF;
    w_ovf_ld   = 1'b0;
    w_wait_nxt = '0;
    PCWr       = 1'b0;
    IRWr       = 1'b0;
    PCSrc      = PCSRC_PC4;
    ALUSrcA    = 1'b0;
    ALUSrcB    = ASB_BUSB;
    ALUctr     = ALU_ADDU;
    ExtOp      = 1'b0;
    RegDst     = 1'b0;
    MemToReg   = 1'b0;
    RegWr      = 1'b0;
    MemRd      = 1'b0;
    MemWr      = 1'b0;
    Illegal    = 1'b0;
    Fault      = 1'b0;

    case (w_cur)
      S_IF: begin
        IRWr    = 1'b1;
        PCWr    = 1'b1;
        PCSrc   = PCSRC_PC4;
        ALUSrcB = ASB_FOUR;
        ALUctr  = ALU_ADDU;
        w_next  = S_ID;
      end
      S_ID: begin
        ALUSrcB = ASB_IMMSH;
        ExtOp   = 1'b1;
        ALUctr  = ALU_ADDU;
        case (w_class)
          CL_R:  w_next = S_EX_R;
          CL_I:  w_next = S_EX_I;
          CL_LS: w_next = S_EX_AD;
          CL_BR: w_next = S_EX_BR;
          CL_J: begin
            PCWr   = 1'b1;
            PCSrc  = PCSRC_JUMP;
            w_next = S_IF;
          end
          default: begin
            Illegal = 1'b1;
            w_next  = S_IF;
          end
        endcase
      end
      S_EX_R: begin
        ALUSrcA = 1'b1;
        ALUSrcB = ASB_BUSB;
        ALUctr  = w_alu_r;
        if (w_func_ok) begin
          w_ovf_ld = 1'b1;
          w_next   = S_WB_R;
        end else begin
          Illegal = 1'b1;
          w_next  = S_IF;
        end
      end
      S_EX_I: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = ASB_IMM;
        ExtOp    = ~w_zext;
        ALUctr   = w_alu_i;
        w_ovf_ld = 1'b1;
        w_next   = S_WB_I;
      end
      S_EX_AD: begin
        ALUSrcA = 1'b1;
        ALUSrcB = ASB_IMM;
        ExtOp   = 1'b1;
        ALUctr  = ALU_ADDU;
        w_next  = w_is_lw ? S_MEM_LD : S_MEM_ST;
      end
      S_EX_BR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = ASB_BUSB;
        ALUctr  = ALU_SUB;
        PCSrc   = PCSRC_BR;
        PCWr    = Z;
        w_next  = S_IF;
      end
      S_MEM_LD, S_MEM_ST: begin
        MemRd = (w_cur == S_MEM_LD);
        MemWr = (w_cur == S_MEM_ST);
        // Ready is checked before the limit so a completion on the last allowed cycle wins.
        if (MemReady) begin
          w_next = (w_cur == S_MEM_LD) ? S_WB_LD : S_IF;
        end else if (w_limit_hit) begin
          Fault  = 1'b1;
          w_next = S_IF;
        end else begin
          w_next     = w_cur;
          w_wait_nxt = r_wait + 1'b1;
        end
      end
      S_WB_R: begin
        RegDst = 1'b1;
        RegWr  = ~(w_ovf_trap & r_ovf);
        w_next = S_IF;
      end
      S_WB_I: begin
        RegWr  = ~(w_ovf_trap & r_ovf);
        w_next = S_IF;
      end
      S_WB_LD: begin
        MemToReg = 1'b1;
        RegWr    = 1'b1;
        w_next   = S_IF;
      end
      default: w_next = S_IF;
    endcase

    if (!Clrn) begin
      PCWr    = 1'b0;
      IRWr    = 1'b0;
      RegWr   = 1'b0;
      MemRd   = 1'b0;
      MemWr   = 1'b0;
      Illegal = 1'b0;
      Fault   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus random instruction mix.
module tb_multicycle_ctrl;

  logic       Clk = 1'b0;
  logic       Clrn;
  logic [5:0] OP, func;
  logic       Z, Overflow, MemReady;
  logic       PCWr, IRWr, ALUSrcA, ExtOp, RegDst, MemToReg, RegWr;
  logic       MemRd, MemWr, Illegal, Fault;
  logic [1:0] PCSrc, ALUSrcB;
  logic [2:0] ALUctr;
  logic [3:0] State;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [5:0] O_R = 6'b000000, O_ADDI = 6'b001000, O_ADDIU = 6'b001001;
  localparam logic [5:0] O_ORI = 6'b001101, O_LW = 6'b100011, O_SW = 6'b101011;
  localparam logic [5:0] O_BEQ = 6'b000100, O_J = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000, F_ADDU = 6'b100001, F_SUB = 6'b100010;
  localparam int TIMEOUT_CYC = 16;  // cycles spent in MEM before Fault (WAIT_LIMIT=15)

  typedef struct packed {
    logic [3:0] st;
    logic       pcwr, irwr;
    logic [1:0] pcsrc;
    logic       asa;
    logic [1:0] asb;
    logic [2:0] alu;
    logic       ext, rdst, m2r, regwr, memrd, memwr, ill, fault;
  } obs_t;

  obs_t exp_q[$];
  obs_t got_q[$];

  multicycle_ctrl #(.WAIT_LIMIT(15), .WAIT_W(4)) dut (
    .Clk(Clk), .Clrn(Clrn), .OP(OP), .func(func), .Z(Z), .Overflow(Overflow),
    .MemReady(MemReady), .PCWr(PCWr), .IRWr(IRWr), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUctr(ALUctr), .ExtOp(ExtOp), .RegDst(RegDst),
    .MemToReg(MemToReg), .RegWr(RegWr), .MemRd(MemRd), .MemWr(MemWr),
    .Illegal(Illegal), .Fault(Fault), .State(State)
  );

  always #5 Clk = ~Clk;

  function automatic obs_t sample();
    obs_t o;
    o = '{st: State, pcwr: PCWr, irwr: IRWr, pcsrc: PCSrc, asa: ALUSrcA, asb: ALUSrcB,
          alu: ALUctr, ext: ExtOp, rdst: RegDst, m2r: MemToReg, regwr: RegWr,
          memrd: MemRd, memwr: MemWr, ill: Illegal, fault: Fault};
    return o;
  endfunction

  // ALU code for an R-type func, or -1 when the func is not part of the subset.
  function automatic int r_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 1;
      6'b100001: return 0;
      6'b100010: return 2;
      6'b100100: return 3;
      6'b100101: return 4;
      6'b101010: return 5;
      6'b101011: return 6;
      default:   return -1;
    endcase
  endfunction

  function automatic bit known_op(input logic [5:0] op);
    return op == O_R || op == O_ADDI || op == O_ADDIU || op == O_ORI ||
           op == O_LW || op == O_SW || op == O_BEQ || op == O_J;
  endfunction

  // Reference: per-cycle expected controls for one instruction, built from the instruction's
  // meaning (fetch, decode, then class-specific steps) with waits = cycles before MemReady.
  task automatic model_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input logic ov, input int waits);
    obs_t o;
    int   code;
    exp_q.delete();
    o = '0; o.st = 0; o.pcwr = 1; o.irwr = 1; o.asb = 2'b01;
    exp_q.push_back(o);
    o = '0; o.st = 1; o.asb = 2'b11; o.ext = 1;
    if (op == O_J) begin
      o.pcwr = 1; o.pcsrc = 2'b10;
      exp_q.push_back(o);
    end else if (!known_op(op)) begin
      o.ill = 1;
      exp_q.push_back(o);
    end else begin
      exp_q.push_back(o);
      o = '0; o.asa = 1;
      if (op == O_R) begin
        code = r_alu(fn);
        o.st = 2;
        if (code < 0) begin
          o.ill = 1;
          exp_q.push_back(o);
        end else begin
          o.alu = 3'(code);
          exp_q.push_back(o);
          o = '0; o.st = 8; o.rdst = 1;
          o.regwr = !(ov && (fn == F_ADD || fn == F_SUB));
          exp_q.push_back(o);
        end
      end else if (op == O_ADDI || op == O_ADDIU || op == O_ORI) begin
        o.st = 3; o.asb = 2'b10; o.ext = (op != O_ORI);
        o.alu = (op == O_ADDI) ? 3'd1 : (op == O_ORI) ? 3'd4 : 3'd0;
        exp_q.push_back(o);
        o = '0; o.st = 9; o.regwr = !(ov && op == O_ADDI);
        exp_q.push_back(o);
      end else if (op == O_BEQ) begin
        o.st = 5; o.alu = 3'd2; o.pcsrc = 2'b01; o.pcwr = z;
        exp_q.push_back(o);
      end else begin
        o.st = 4; o.asb = 2'b10; o.ext = 1;
        exp_q.push_back(o);
        for (int i = 0; i < TIMEOUT_CYC; i++) begin
          o = '0;
          o.st = (op == O_LW) ? 4'd6 : 4'd7;
          o.memrd = (op == O_LW); o.memwr = (op == O_SW);
          if (i >= waits) begin
            exp_q.push_back(o);
            if (op == O_LW) begin
              o = '0; o.st = 10; o.m2r = 1; o.regwr = 1;
              exp_q.push_back(o);
            end
            break;
          end
          if (i == TIMEOUT_CYC - 1) o.fault = 1;
          exp_q.push_back(o);
        end
      end
    end
  endtask

  // Drive one instruction for n cycles; MemReady rises once 'waits' MEM cycles have passed.
  task automatic exec(input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input logic ov, input int waits, input int n);
    OP = op; func = fn; Z = z; Overflow = ov;
    got_q.delete();
    for (int k = 0; k < n; k++) begin
      if (op == O_LW || op == O_SW) MemReady = (k >= 3 + waits);
      else                          MemReady = 1'($urandom);
      @(negedge Clk);
      got_q.push_back(sample());
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic ov, input int waits);
    model_instr(op, fn, z, ov, waits);
    exec(op, fn, z, ov, waits, exp_q.size());
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      vectors++;
      if (State !== 4'd0 || PCWr !== 1'b0 || IRWr !== 1'b0 || ALUSrcB !== 2'b01) begin
        miscompares++;
        $display("FAIL reset_hold cyc=%0d got st=%0d pcwr=%b irwr=%b asb=%b exp st=0 pcwr=0 irwr=0 asb=01",
                 i, State, PCWr, IRWr, ALUSrcB);
      end
      @(posedge Clk);
      #1;
    end
    Clrn = 1'b1;
    run(O_R, F_ADDU, 1'b0, 1'b0, 0);
    vectors++;
    if (got_q[0].pcwr !== 1'b1 || got_q[0].irwr !== 1'b1 || got_q[0].st !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_release got %h exp IF with PCWr=IRWr=1", got_q[0]);
    end
  endtask

  task automatic test_alu_r();
    logic [3:0] seq [4];
    seq = '{4'd0, 4'd1, 4'd2, 4'd8};
    run(O_R, F_ADDU, 1'b0, 1'b0, 0);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (got_q[k].st !== seq[k] || got_q[k].regwr !== (k == 3) || got_q[k].rdst !== (k == 3)) begin
        miscompares++;
        $display("FAIL addu_seq cyc=%0d got st=%0d regwr=%b rdst=%b exp st=%0d regwr=%b rdst=%b",
                 k, got_q[k].st, got_q[k].regwr, got_q[k].rdst, seq[k], k == 3, k == 3);
      end
    end
  endtask

  task automatic test_overflow();
    run(O_R, F_ADD, 1'b0, 1'b1, 0);
    vectors++;
    if (got_q[3].st !== 4'd8 || got_q[3].regwr !== 1'b0) begin
      miscompares++;
      $display("FAIL add_ovf got st=%0d regwr=%b exp st=8 regwr=0", got_q[3].st, got_q[3].regwr);
    end
    run(O_R, F_ADDU, 1'b0, 1'b1, 0);
    vectors++;
    if (got_q[3].st !== 4'd8 || got_q[3].regwr !== 1'b1) begin
      miscompares++;
      $display("FAIL addu_ovf got st=%0d regwr=%b exp st=8 regwr=1", got_q[3].st, got_q[3].regwr);
    end
    run(O_ADDI, 6'h15, 1'b0, 1'b1, 0);
    vectors++;
    if (got_q[3].st !== 4'd9 || got_q[3].regwr !== 1'b0) begin
      miscompares++;
      $display("FAIL addi_ovf got st=%0d regwr=%b exp st=9 regwr=0", got_q[3].st, got_q[3].regwr);
    end
  endtask

  task automatic test_load_wait();
    int nrd;
    run(O_LW, 6'h00, 1'b0, 1'b0, 3);
    nrd = 0;
    foreach (got_q[k]) if (got_q[k].st == 4'd6 && got_q[k].memrd) nrd++;
    vectors++;
    if (nrd != 4 || got_q[7].st !== 4'd10 || got_q[7].m2r !== 1'b1 || got_q[7].regwr !== 1'b1) begin
      miscompares++;
      $display("FAIL lw_wait3 got memrd_cycles=%0d last=%h exp memrd_cycles=4 WB_LD m2r=1 regwr=1",
               nrd, got_q[7]);
    end
    // Ready on exactly the limit cycle completes the load.
    run(O_LW, 6'h00, 1'b0, 1'b0, 15);
    vectors++;
    if (got_q[19].st !== 4'd10 || got_q[18].fault !== 1'b0 || got_q[19].regwr !== 1'b1) begin
      miscompares++;
      $display("FAIL lw_limit got mem_last=%h wb=%h exp no fault then WB_LD", got_q[18], got_q[19]);
    end
  endtask

  task automatic test_store_timeout();
    int nst, nflt, nwr;
    run(O_SW, 6'h00, 1'b0, 1'b0, 1000);
    nst = 0; nflt = 0; nwr = 0;
    foreach (got_q[k]) begin
      if (got_q[k].st == 4'd7) nst++;
      if (got_q[k].fault) nflt++;
      if (got_q[k].regwr) nwr++;
    end
    vectors++;
    if (nst != 16 || nflt != 1 || got_q[18].fault !== 1'b1 || nwr != 0) begin
      miscompares++;
      $display("FAIL sw_timeout got st7_cycles=%0d faults=%0d fault_at18=%b regwr=%0d exp 16 1 1 0",
               nst, nflt, got_q[18].fault, nwr);
    end
    run(O_J, 6'h00, 1'b0, 1'b0, 0);
    vectors++;
    if (got_q[0].st !== 4'd0) begin
      miscompares++;
      $display("FAIL after_fault got st=%0d exp st=0", got_q[0].st);
    end
  endtask

  task automatic test_branch_jump_illegal();
    run(O_BEQ, 6'h00, 1'b1, 1'b0, 0);
    vectors++;
    if (got_q[2].st !== 4'd5 || got_q[2].pcwr !== 1'b1 || got_q[2].pcsrc !== 2'b01) begin
      miscompares++;
      $display("FAIL beq_taken got %h exp st=5 pcwr=1 pcsrc=01", got_q[2]);
    end
    run(O_BEQ, 6'h00, 1'b0, 1'b0, 0);
    vectors++;
    if (got_q[2].st !== 4'd5 || got_q[2].pcwr !== 1'b0) begin
      miscompares++;
      $display("FAIL beq_not_taken got %h exp st=5 pcwr=0", got_q[2]);
    end
    run(O_J, 6'h00, 1'b0, 1'b0, 0);
    vectors++;
    if (got_q[1].st !== 4'd1 || got_q[1].pcwr !== 1'b1 || got_q[1].pcsrc !== 2'b10) begin
      miscompares++;
      $display("FAIL jump got %h exp st=1 pcwr=1 pcsrc=10", got_q[1]);
    end
    run(6'b111111, 6'h00, 1'b0, 1'b0, 0);
    vectors++;
    if (got_q[1].st !== 4'd1 || got_q[1].ill !== 1'b1 || got_q[0].ill !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_op got if=%h id=%h exp Illegal only in ID", got_q[0], got_q[1]);
    end
    run(O_R, 6'b111111, 1'b0, 1'b0, 0);
    vectors++;
    if (got_q[2].st !== 4'd2 || got_q[2].ill !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_func got %h exp st=2 Illegal=1", got_q[2]);
    end
    run(O_ADDIU, 6'h00, 1'b0, 1'b0, 0);
    vectors++;
    if (got_q[0].st !== 4'd0 || got_q[0].ill !== 1'b0) begin
      miscompares++;
      $display("FAIL post_illegal got st=%0d ill=%b exp st=0 ill=0", got_q[0].st, got_q[0].ill);
    end
  endtask

  task automatic test_reset_mid_lw();
    model_instr(O_LW, 6'h00, 1'b0, 1'b0, 10);
    exec(O_LW, 6'h00, 1'b0, 1'b0, 10, 5);
    Clrn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      vectors++;
      if (State !== 4'd0 || RegWr !== 1'b0 || MemWr !== 1'b0 || MemRd !== 1'b0 ||
          PCWr !== 1'b0 || IRWr !== 1'b0 || ALUSrcB !== 2'b01) begin
        miscompares++;
        $display("FAIL reset_mid_lw cyc=%0d got %h exp st=0 no strobes asb=01", i, sample());
      end
      @(posedge Clk);
      #1;
    end
    Clrn = 1'b1;
    run(O_SW, 6'h00, 1'b0, 1'b0, 0);
    vectors++;
    if (got_q[0] !== exp_q[0] || got_q[3].memwr !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_resume got if=%h mem=%h exp if=%h memwr=1", got_q[0], got_q[3], exp_q[0]);
    end
  endtask

  task automatic test_random();
    logic [5:0] fv [7];
    logic [5:0] op, fn;
    int         sel, waits;
    fv = '{6'b100000, 6'b100001, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b101011};
    for (int n = 0; n < 250; n++) begin
      sel   = $urandom_range(0, 9);
      fn    = 6'($urandom);
      waits = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) waits = ($urandom_range(0, 1) == 0) ? 15 : 20;
      case (sel)
        0: begin op = O_R; fn = fv[$urandom_range(0, 6)]; end
        1: begin op = O_R; while (r_alu(fn) >= 0) fn = 6'($urandom); end
        2: op = O_ADDI;
        3: op = O_ADDIU;
        4: op = O_ORI;
        5: op = O_LW;
        6: op = O_SW;
        7: op = O_BEQ;
        8: op = O_J;
        default: begin op = 6'($urandom); while (known_op(op)) op = 6'($urandom); end
      endcase
      run(op, fn, 1'($urandom), 1'($urandom), waits);
      foreach (exp_q[k]) begin
        vectors++;
        if (got_q[k] !== exp_q[k]) begin
          miscompares++;
          $display("FAIL random n=%0d op=%b fn=%b cyc=%0d got %h exp %h",
                   n, op, fn, k, got_q[k], exp_q[k]);
        end
      end
    end
  endtask

  initial begin
    Clrn = 1'b0; OP = '0; func = '0; Z = 1'b0; Overflow = 1'b0; MemReady = 1'b0;
    @(posedge Clk);
    #1;
    test_reset();
    test_alu_r();
    test_overflow();
    test_load_wait();
    test_store_timeout();
    test_branch_jump_illegal();
    test_reset_mid_lw();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
